// File: rtl/sirius_axi_pkg.sv
// Shared types for the AXI read arbiter slice.
//   burst_t      : AXI arburst encodings used by the requesters
//   RESP_*       : AXI rresp codes the arbiter distinguishes
//   arb_state_t  : arbiter transaction phases
package sirius_axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } arb_state_t;

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational request picker.
//   req_i     : per-channel request vector
//   ptr_i     : index of the channel granted most recently (round-robin origin)
//   rr_mode_i : 0 = lowest index wins, 1 = search upward starting at ptr_i+1
//   grant_o   : one-hot grant (all zero when nothing requests)
//   idx_o     : binary index of the granted channel
module arb_rr_picker #(
  parameter int NUM_CH = 3,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  input  logic              rr_mode_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [IDX_W-1:0]  idx_o
);

  // Walk the channels in search order; the first requester found wins.
  // In round-robin mode the walk starts one past the previous winner and
  // wraps, so the previous winner is considered last.
  always_comb begin
    int cand;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rr_mode_i) begin
        cand = (int'(ptr_i) + k + 1) % NUM_CH;
      end else begin
        cand = k;
      end
      if (!found && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        idx_o         = IDX_W'(cand);
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// N-channel read arbiter onto a single AXI4 AR/R master, one transaction
// outstanding at a time.
//   clk_i/rst_i          : clock, synchronous active-high reset
//   req_*_i / req_ready_o: per-channel request payloads and acceptance pulse
//   resp_*_o             : read beats steered to the owning channel
//   protocol_err_o       : sticky flag, rlast disagreed with the beat count
//   ar*_o / arready_i    : AXI read-address channel
//   r*_i / rready_o      : AXI read-data channel
module axi_read_arbiter
  import sirius_axi_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int PRIO_MODE = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CH-1:0]        req_valid_i,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_CH*8-1:0]      req_len_i,
  input  logic [NUM_CH*3-1:0]      req_size_i,
  input  logic [NUM_CH*2-1:0]      req_burst_i,
  output logic [NUM_CH-1:0]        req_ready_o,
  output logic [DATA_W-1:0]        resp_data_o,
  output logic [NUM_CH-1:0]        resp_valid_o,
  output logic [NUM_CH-1:0]        resp_last_o,
  output logic [NUM_CH-1:0]        resp_err_o,
  output logic                     protocol_err_o,
  output logic [ID_W-1:0]          arid_o,
  output logic [ADDR_W-1:0]        araddr_o,
  output logic [7:0]               arlen_o,
  output logic [2:0]               arsize_o,
  output logic [1:0]               arburst_o,
  output logic                     arvalid_o,
  input  logic                     arready_i,
  input  logic [ID_W-1:0]          rid_i,
  input  logic [DATA_W-1:0]        rdata_i,
  input  logic [1:0]               rresp_i,
  input  logic                     rlast_i,
  input  logic                     rvalid_i,
  output logic                     rready_o
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [7:0]        beatCnt_q, beatCnt_d;
  logic              protoErr_q, protoErr_d;

  logic [ADDR_W-1:0] chAddr  [NUM_CH];
  logic [7:0]        chLen   [NUM_CH];
  logic [2:0]        chSize  [NUM_CH];
  logic [1:0]        chBurst [NUM_CH];

  logic [NUM_CH-1:0] pickGrant;
  logic [IDX_W-1:0]  pickIdx;
  logic              pickAny;
  logic [NUM_CH-1:0] ownerMask;
  logic              beatErr;

  for (genvar i = 0; i < NUM_CH; i++) begin : gUnpack
    assign chAddr[i]  = req_addr_i[i*ADDR_W +: ADDR_W];
    assign chLen[i]   = req_len_i[i*8 +: 8];
    assign chSize[i]  = req_size_i[i*3 +: 3];
    assign chBurst[i] = req_burst_i[i*2 +: 2];
  end

  arb_rr_picker #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) uPicker (
    .req_i     (req_valid_i),
    .ptr_i     (ptr_q),
    .rr_mode_i (PRIO_MODE == 1),
    .grant_o   (pickGrant),
    .idx_o     (pickIdx)
  );

  assign pickAny   = |pickGrant;
  assign ownerMask = {{(NUM_CH-1){1'b0}}, 1'b1} << grant_q;

  // The AR payload comes straight from the latched request, so it cannot
  // move while arvalid waits for arready.
  assign arid_o         = ID_W'(grant_q);
  assign araddr_o       = addr_q;
  assign arlen_o        = len_q;
  assign arsize_o       = size_q;
  assign arburst_o      = burst_q;
  assign protocol_err_o = protoErr_q;

  // A beat is flagged when the slave reports an error or answers with an
  // ID other than the one issued for the current transaction.
  assign beatErr = (rresp_i != RESP_OKAY) || (rid_i != arid_o);

  // State register; reset abandons any transaction in flight and points
  // the round-robin origin at the last channel so channel 0 goes first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      ptr_q      <= IDX_W'(NUM_CH - 1);
      beatCnt_q  <= '0;
      protoErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      ptr_q      <= ptr_d;
      beatCnt_q  <= beatCnt_d;
      protoErr_q <= protoErr_d;
    end
  end

  // Next-state and output logic. Arbitration happens only in IDLE, which
  // guarantees one idle cycle between back-to-back transactions. The
  // round-robin origin advances only once the address is accepted.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    ptr_d        = ptr_q;
    beatCnt_d    = beatCnt_q;
    protoErr_d   = protoErr_q;
    req_ready_o  = '0;
    resp_data_o  = '0;
    resp_valid_o = '0;
    resp_last_o  = '0;
    resp_err_o   = '0;
    arvalid_o    = 1'b0;
    rready_o     = 1'b0;

    case (state_q)
      IDLE: begin
        if (pickAny) begin
          grant_d = pickIdx;
          addr_d  = chAddr[pickIdx];
          len_d   = chLen[pickIdx];
          size_d  = chSize[pickIdx];
          burst_d = chBurst[pickIdx];
          state_d = ADDR;
        end
      end
      ADDR: begin
        arvalid_o = 1'b1;
        if (arready_i) begin
          req_ready_o = ownerMask;
          ptr_d       = grant_q;
          beatCnt_d   = '0;
          state_d     = DATA;
        end
      end
      DATA: begin
        rready_o = 1'b1;
        if (rvalid_i) begin
          resp_data_o  = rdata_i;
          resp_valid_o = ownerMask;
          resp_last_o  = rlast_i ? ownerMask : '0;
          resp_err_o   = beatErr ? ownerMask : '0;
          beatCnt_d    = beatCnt_q + 8'd1;
          // Beat count is zero-based, so the final beat is the one where
          // the count equals arlen; rlast must coincide with exactly that.
          if (rlast_i != (beatCnt_q == len_q)) begin
            protoErr_d = 1'b1;
          end
          if (rlast_i) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
